lbuf_rdctrl: RTL and testbench

- Downstream consumer of the output sync generator.
- Turns the generator's line-buffer coordinates (hcnt_lbuf, vcnt_lbuf) and timing (HSYNC/VSYNC/DE) into line-buffer RAM read addresses.
- Expands returned 12-bit CPS2 RGB444 pixels to RGB888 and delays the sync/DE signals so they stay aligned with pixel data at the HDMI/DVI transmitter input.
- Pixels outside the buffered 384-wide window inside DE are driven with a constant border colour.

---
 rtl/lbuf_rdctrl.sv | 131 +++++++++++++
 tb/tb_lbuf_rdctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lbuf_rdctrl.sv
// Line-buffer read control: RAM address generation, RGB444->RGB888 expansion, sync alignment.
// Define LBUF_SCANLINES_EN to dim the fifth subline of every buffered line (scanline effect).
module lbuf_rdctrl #(
    parameter int          LBUF_WIDTH  = 384,
    parameter int          NUM_LBUF    = 40,
    parameter int          RAM_LATENCY = 2,
    parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
    input  logic        PCLK,
    input  logic        reset_n,
    input  logic        HSYNC_in,
    input  logic        VSYNC_in,
    input  logic        DE_in,
    input  logic [8:0]  hcnt_lbuf,
    input  logic [5:0]  vcnt_lbuf,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [11:0] ram_rdata,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        HSYNC_out,
    output logic        VSYNC_out,
    output logic        DE_out
);
    localparam int          D     = RAM_LATENCY + 1;
    localparam logic [8:0]  H_MAX = 9'(LBUF_WIDTH);
    localparam logic [5:0]  V_MAX = 6'(NUM_LBUF);
    localparam logic [14:0] W15   = 15'(LBUF_WIDTH);

    logic        in_win;
    logic [14:0] addr;
    logic        dim;
    logic [7:0]  r8, g8, b8;
    logic [23:0] rgb_px;

    logic [D-1:0] hs_p, vs_p, de_p, win_p;

    assign in_win = DE_in && (hcnt_lbuf < H_MAX) && (vcnt_lbuf < V_MAX);
    assign addr   = 15'(vcnt_lbuf) * W15 + 15'(hcnt_lbuf);

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr <= '0;
            rd_en   <= 1'b0;
        end else begin
            if (in_win)
                rd_addr <= addr;
            rd_en <= in_win;
        end
    end

    // Pipe depth plus the output register equals RAM_LATENCY+2.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            hs_p  <= '1;
            vs_p  <= '1;
            de_p  <= '0;
            win_p <= '0;
        end else begin
            hs_p  <= {hs_p[D-2:0], HSYNC_in};
            vs_p  <= {vs_p[D-2:0], VSYNC_in};
            de_p  <= {de_p[D-2:0], DE_in};
            win_p <= {win_p[D-2:0], in_win};
        end
    end

`ifdef LBUF_SCANLINES_EN
    logic       hs_prev;
    logic [2:0] subline;
    logic [5:0] last_vcnt;
    logic [2:0] sl_p [D];

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev   <= 1'b1;
            subline   <= '0;
            last_vcnt <= '0;
            for (int i = 0; i < D; i++)
                sl_p[i] <= '0;
        end else begin
            hs_prev <= HSYNC_in;
            if (hs_prev && !HSYNC_in) begin
                if (vcnt_lbuf != last_vcnt) begin
                    subline   <= '0;
                    last_vcnt <= vcnt_lbuf;
                end else if (subline != 3'd7) begin
                    subline <= subline + 3'd1;
                end
            end
            sl_p[0] <= subline;
            for (int i = 1; i < D; i++)
                sl_p[i] <= sl_p[i-1];
        end
    end

    assign dim = (sl_p[D-1] == 3'd4);
`else
    assign dim = 1'b0;
`endif

    assign r8 = {ram_rdata[11:8], ram_rdata[11:8]};
    assign g8 = {ram_rdata[7:4], ram_rdata[7:4]};
    assign b8 = {ram_rdata[3:0], ram_rdata[3:0]};

    always_comb begin
        rgb_px = {r8, g8, b8};
        if (dim)
            rgb_px = {1'b0, r8[7:1], 1'b0, g8[7:1], 1'b0, b8[7:1]};
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            {R_out, G_out, B_out} <= '0;
            HSYNC_out <= 1'b1;
            VSYNC_out <= 1'b1;
            DE_out    <= 1'b0;
        end else begin
            HSYNC_out <= hs_p[D-1];
            VSYNC_out <= vs_p[D-1];
            DE_out    <= de_p[D-1];
            if (!de_p[D-1])
                {R_out, G_out, B_out} <= '0;
            else if (!win_p[D-1])
                {R_out, G_out, B_out} <= BORDER_RGB;
            else
                {R_out, G_out, B_out} <= rgb_px;
        end
    end

endmodule

// File: tb/tb_lbuf_rdctrl.sv
// Directed bench for lbuf_rdctrl with a 2-cycle RAM model.
// Scanline vectors are compiled in when LBUF_SCANLINES_EN is defined.
module tb_lbuf_rdctrl;
    localparam logic [23:0] BORDER = 24'h123456;

    logic        PCLK = 1'b0;
    logic        reset_n;
    logic        HSYNC_in, VSYNC_in, DE_in;
    logic [8:0]  hcnt_lbuf;
    logic [5:0]  vcnt_lbuf;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [11:0] ram_rdata;
    logic [7:0]  R_out, G_out, B_out;
    logic        HSYNC_out, VSYNC_out, DE_out;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] mem [16384];
    logic [11:0] q1;

    lbuf_rdctrl #(
        .LBUF_WIDTH(384),
        .NUM_LBUF(40),
        .RAM_LATENCY(2),
        .BORDER_RGB(BORDER)
    ) dut (
        .PCLK(PCLK),
        .reset_n(reset_n),
        .HSYNC_in(HSYNC_in),
        .VSYNC_in(VSYNC_in),
        .DE_in(DE_in),
        .hcnt_lbuf(hcnt_lbuf),
        .vcnt_lbuf(vcnt_lbuf),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .ram_rdata(ram_rdata),
        .R_out(R_out),
        .G_out(G_out),
        .B_out(B_out),
        .HSYNC_out(HSYNC_out),
        .VSYNC_out(VSYNC_out),
        .DE_out(DE_out)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        q1        <= mem[rd_addr];
        ram_rdata <= q1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " rgb"}, {8'h0, R_out, G_out, B_out}, 32'h0);
        chk({tag, " de"}, {31'h0, DE_out}, 32'h0);
        chk({tag, " syncs"}, {30'h0, HSYNC_out, VSYNC_out}, 32'h3);
        chk({tag, " rd_en"}, {31'h0, rd_en}, 32'h0);
    endtask

    logic [8:0]  sweep_h [4];
    logic [23:0] sweep_rgb [4];

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = 12'(i);
        mem[15359] = 12'hA5F;
        mem[2688]  = 12'hFFF;
        mem[3072]  = 12'hFFF;
        q1 = '0;
        ram_rdata = '0;

        reset_n = 1'b0;
        HSYNC_in = 1'b1; VSYNC_in = 1'b1; DE_in = 1'b0;
        hcnt_lbuf = '0; vcnt_lbuf = '0;
        tick(); tick();
        chk_rst("reset");
        chk("reset rd_addr", {17'h0, rd_addr}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Last buffer address, with an HSYNC falling edge alongside.
        DE_in = 1'b1; vcnt_lbuf = 6'd39; hcnt_lbuf = 9'd383; HSYNC_in = 1'b0;
        tick();
        chk("addr max", {17'h0, rd_addr}, 32'd15359);
        chk("addr rd_en", {31'h0, rd_en}, 32'd1);
        DE_in = 1'b0; HSYNC_in = 1'b1; hcnt_lbuf = '0; vcnt_lbuf = '0;
        tick();
        chk("addr hold", {17'h0, rd_addr}, 32'd15359);
        chk("addr rd_en off", {31'h0, rd_en}, 32'd0);
        tick();
        chk("lat early de", {31'h0, DE_out}, 32'd0);
        chk("lat early hs", {31'h0, HSYNC_out}, 32'd1);
        tick();
        chk("lat rgb", {8'h0, R_out, G_out, B_out}, 32'hAA55FF);
        chk("lat de", {31'h0, DE_out}, 32'd1);
        chk("lat hs", {31'h0, HSYNC_out}, 32'd0);
        tick();
        chk("lat after rgb", {8'h0, R_out, G_out, B_out}, 32'h0);
        chk("lat after hs", {31'h0, HSYNC_out}, 32'd1);

        // Border pixel inside DE, followed by blanking.
        DE_in = 1'b1; vcnt_lbuf = 6'd5; hcnt_lbuf = 9'd416;
        tick();
        chk("border rd_en", {31'h0, rd_en}, 32'd0);
        DE_in = 1'b0;
        tick(); tick(); tick();
        chk("border rgb", {8'h0, R_out, G_out, B_out}, {8'h0, BORDER});
        chk("border de", {31'h0, DE_out}, 32'd1);
        tick();
        chk("blank rgb", {8'h0, R_out, G_out, B_out}, 32'h0);
        chk("blank de", {31'h0, DE_out}, 32'd0);

        // hcnt wrap 510,511,0,1 on line 2, VSYNC pulse on the second pixel.
        sweep_h   = '{9'd510, 9'd511, 9'd0, 9'd1};
        sweep_rgb = '{BORDER, BORDER, 24'h330000, 24'h330011};
        vcnt_lbuf = 6'd2;
        for (int i = 0; i < 8; i++) begin
            DE_in = (i < 4);
            hcnt_lbuf = (i < 4) ? sweep_h[i] : 9'd0;
            VSYNC_in = (i != 1);
            tick();
            if (i < 4)
                chk($sformatf("wrap rd_en %0d", i), {31'h0, rd_en}, {31'h0, i >= 2});
            if (i == 2 || i == 3)
                chk($sformatf("wrap addr %0d", i), {17'h0, rd_addr}, 32'd766 + 32'(i));
            if (i >= 3 && i < 7)
                chk($sformatf("wrap rgb %0d", i - 3), {8'h0, R_out, G_out, B_out},
                    {8'h0, sweep_rgb[i-3]});
            if (i >= 3)
                chk($sformatf("wrap vs %0d", i), {31'h0, VSYNC_out}, {31'h0, i != 4});
        end

        // Reset asserted mid-stream flushes the pipe.
        DE_in = 1'b1; vcnt_lbuf = 6'd0; hcnt_lbuf = 9'd10;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk_rst("midrst");
        reset_n = 1'b1;
        tick();
        chk("post rst rd_en", {31'h0, rd_en}, 32'd1);
        chk("post rst addr", {17'h0, rd_addr}, 32'd10);
        tick(); tick();
        chk("post rst early de", {31'h0, DE_out}, 32'd0);
        tick();
        chk("post rst rgb", {8'h0, R_out, G_out, B_out}, 32'h0000AA);
        chk("post rst de", {31'h0, DE_out}, 32'd1);
        DE_in = 1'b0;
        tick(); tick(); tick(); tick();

`ifdef LBUF_SCANLINES_EN
        // Five lines on buffer 7, then one on buffer 8.
        for (int ln = 0; ln < 6; ln++) begin
            vcnt_lbuf = (ln < 5) ? 6'd7 : 6'd8;
            hcnt_lbuf = 9'd0;
            HSYNC_in = 1'b0; DE_in = 1'b0;
            tick();
            HSYNC_in = 1'b1; DE_in = 1'b1;
            tick();
            DE_in = 1'b0;
            tick(); tick(); tick();
            chk($sformatf("scan rgb %0d", ln), {8'h0, R_out, G_out, B_out},
                (ln == 4) ? 32'h7F7F7F : 32'hFFFFFF);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
